// File: rtl/midi_out_sched.sv
// midi_out_sched: round-robin whole-message MIDI scheduler feeding one byte serializer; running status via MIDI_RUNNING_STATUS_EN
module midi_out_sched #(
    parameter int NUM_REQ    = 2,
    parameter int RS_REFRESH = 3000
) (
    input  logic                   baud_clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [8*NUM_REQ-1:0]   req_status,
    input  logic [8*NUM_REQ-1:0]   req_data1,
    input  logic [8*NUM_REQ-1:0]   req_data2,
    input  logic [2*NUM_REQ-1:0]   req_bytes,
    output logic [7:0]             tx_byte,
    output logic                   tx_valid,
    input  logic                   tx_ready,
    output logic                   busy,
    output logic [2:0]             grant_idx
);
    typedef enum logic [1:0] {IDLE, SEND_ST, SEND_D1, SEND_D2} state_t;
    state_t     r_state, w_next;
    logic [2:0] r_ptr, r_grant, w_win;
    logic       w_any, w_accept, w_skip;
    logic [7:0] r_tx_byte, r_d1, r_d2, w_tx_byte, w_st, w_d1, w_d2;
    logic [1:0] r_bytes, w_bytes;

    // first valid requester after the last grant, wrapping
    always_comb begin
        w_win = '0;
        w_any = 1'b0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            if (req_valid[(int'(r_ptr) + k) % NUM_REQ]) begin
                w_win = 3'((int'(r_ptr) + k) % NUM_REQ);
                w_any = 1'b1;
            end
        end
    end

    assign w_st      = req_status[8*int'(w_win) +: 8];
    assign w_d1      = req_data1[8*int'(w_win) +: 8];
    assign w_d2      = req_data2[8*int'(w_win) +: 8];
    assign w_bytes   = req_bytes[2*int'(w_win) +: 2];
    assign w_accept  = (r_state == IDLE) && w_any;
    assign req_ready = w_accept ? NUM_REQ'(1) << w_win : '0;
    assign tx_valid  = (r_state != IDLE);
    assign busy      = (r_state != IDLE);
    assign tx_byte   = r_tx_byte;
    assign grant_idx = r_grant;

`ifdef MIDI_RUNNING_STATUS_EN
    localparam int CW = $clog2(RS_REFRESH + 1);
    logic [7:0]    r_last;
    logic          r_rs_vld, w_voice;
    logic [CW-1:0] r_idle_cnt;

    assign w_voice = (w_st >= 8'h80) && (w_st <= 8'hEF);
    assign w_skip  = w_voice && r_rs_vld && (w_st == r_last) && (w_bytes >= 2'd2);

    // last voice status seen; only meaningful while r_rs_vld is set, so it needs no reset
    always_ff @(posedge baud_clk) begin
        if (w_accept && w_bytes != 2'd0 && w_voice)
            r_last <= w_st;
    end

    // running-status validity: set by voice, cleared by system common or a long idle gap
    always_ff @(posedge baud_clk or negedge rst) begin
        if (!rst) begin
            r_rs_vld   <= 1'b0;
            r_idle_cnt <= '0;
        end else if (r_state != IDLE || w_accept) begin
            r_idle_cnt <= '0;
            if (w_accept && w_bytes != 2'd0) begin
                if (w_voice)
                    r_rs_vld <= 1'b1;
                else if (w_st[7:3] == 5'b11110)
                    r_rs_vld <= 1'b0;
            end
        end else begin
            if (r_idle_cnt != CW'(RS_REFRESH))
                r_idle_cnt <= r_idle_cnt + 1'b1;
            if (r_idle_cnt >= CW'(RS_REFRESH - 1))
                r_rs_vld <= 1'b0;
        end
    end
`else
    assign w_skip = (RS_REFRESH < 0);
`endif

    // next state and the byte to present after this edge
    always_comb begin
        w_next    = r_state;
        w_tx_byte = r_tx_byte;
        case (r_state)
            IDLE: begin
                if (w_accept && w_bytes != 2'd0) begin
                    w_next    = w_skip ? SEND_D1 : SEND_ST;
                    w_tx_byte = w_skip ? w_d1 : w_st;
                end
            end
            SEND_ST: begin
                if (tx_ready) begin
                    w_next    = (r_bytes >= 2'd2) ? SEND_D1 : IDLE;
                    w_tx_byte = r_d1;
                end
            end
            SEND_D1: begin
                if (tx_ready) begin
                    w_next    = (r_bytes == 2'd3) ? SEND_D2 : IDLE;
                    w_tx_byte = r_d2;
                end
            end
            SEND_D2: begin
                if (tx_ready)
                    w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // state register; reset abandons any message in flight
    always_ff @(posedge baud_clk or negedge rst) begin
        if (!rst)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    // message latch, output byte and round-robin pointer
    always_ff @(posedge baud_clk or negedge rst) begin
        if (!rst) begin
            r_tx_byte <= 8'h00;
            r_ptr     <= 3'(NUM_REQ - 1);
            r_grant   <= 3'd0;
            r_d1      <= 8'h00;
            r_d2      <= 8'h00;
            r_bytes   <= 2'd0;
        end else begin
            r_tx_byte <= w_tx_byte;
            if (w_accept) begin
                r_ptr   <= w_win;
                r_grant <= w_win;
                r_d1    <= w_d1;
                r_d2    <= w_d2;
                r_bytes <= w_bytes;
            end
        end
    end
endmodule
